// File: rtl/doodle_game_ctrl_pkg.sv
// Shared types and constants for the doodle-jump game controller and its jumper handshake.
package doodle_pkg;

   typedef enum logic [5:0] {
      ST_UNK    = 6'b000000,
      ST_IDLE   = 6'b000001,
      ST_LAUNCH = 6'b000010,
      ST_AIR    = 6'b000100,
      ST_JUDGE  = 6'b001000,
      ST_ACK    = 6'b010000,
      ST_OVER   = 6'b100000
   } ctrlState_t;

   // Jumper one-hot state, packed as {q_Done, q_Down, q_Up, q_I}
   localparam logic [3:0] JMP_I    = 4'b0001;
   localparam logic [3:0] JMP_UP   = 4'b0010;
   localparam logic [3:0] JMP_DOWN = 4'b0100;
   localparam logic [3:0] JMP_DONE = 4'b1000;

   localparam logic [7:0] JUMP_DEF      = 8'd40;
   localparam logic [7:0] GAP_MIN_DEF   = 8'd8;
   localparam logic [1:0] LIVES_DEF     = 2'd3;
   localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;
   localparam logic [7:0] LFSR_TAPS     = 8'hB8;

   // Right-shifting Galois step for x^8+x^6+x^5+x^4+1; never reaches zero from a non-zero seed
   function automatic logic [7:0] lfsrNext(input logic [7:0] cur);
      return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
   endfunction

   function automatic logic [7:0] gapFrom(input logic [7:0] lfsr, input logic [7:0] gapMin);
      return gapMin + {2'b00, lfsr[5:0]};
   endfunction

endpackage

// File: rtl/doodle_game_ctrl_if.sv
// Start/Ack handshake and state/height feedback between the game controller and the jumper core.
interface doodle_game_ctrl_if;

   logic       Start;
   logic       Ack;
   logic [7:0] Jin;
   logic       q_I;
   logic       q_Up;
   logic       q_Down;
   logic       q_Done;
   logic [7:0] Curr;

   modport master (
      output Start, Ack, Jin,
      input  q_I, q_Up, q_Down, q_Done, Curr
   );

   modport slave (
      input  Start, Ack, Jin,
      output q_I, q_Up, q_Down, q_Done, Curr
   );

endinterface

// File: rtl/doodle_game_ctrl_gap_fifo.sv
// Synchronous 8-bit queue of platform gaps; push+pop in one cycle is allowed whenever it is not empty.
module doodle_gap_fifo #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wrPtr_q, wrPtr_d;
   logic [AW:0] rdPtr_q, rdPtr_d;
   logic [AW:0] count;
   logic        doPush, doPop;

   assign count = wrPtr_q - rdPtr_q;
   assign full  = (count == DEPTH_V);
   assign empty = (count == '0);
   assign dout  = mem_q[rdPtr_q[AW-1:0]];

   // A full queue may still accept a push when the head leaves in the same cycle
   always_comb begin
      doPop   = pop && !empty && !flush;
      doPush  = push && !flush && (!full || doPop);
      wrPtr_d = flush ? '0 : wrPtr_q + (AW+1)'(doPush);
      rdPtr_d = flush ? '0 : rdPtr_q + (AW+1)'(doPop);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (doPush) begin
         mem_q[wrPtr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/doodle_game_ctrl.sv
// Game controller: launches jumps, judges landings against LFSR platform gaps, tracks score/level/lives.
// Optional watchdog forcing a miss on a stuck jumper is enabled by defining DOODLE_WATCHDOG_EN.
module doodle_game_ctrl
   import doodle_pkg::*;
#(
`ifdef DOODLE_WATCHDOG_EN
   parameter int unsigned WD_CYCLES  = 1024,
`endif
   parameter logic [7:0]  JUMP       = JUMP_DEF,
   parameter logic [1:0]  LIVES      = LIVES_DEF,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  LFSR_SEED  = LFSR_SEED_DEF,
   parameter logic [7:0]  GAP_MIN    = GAP_MIN_DEF
) (
   input  logic                Clk,
   input  logic                Reset,
`ifdef DOODLE_WATCHDOG_EN
   output logic                WdTrip,
`endif
   input  logic                BtnStart,
   input  logic                BtnAck,
   doodle_game_ctrl_if.master  jmp,
   output logic [7:0]          Platform,
   output logic [15:0]         TotalScore,
   output logic [7:0]          Level,
   output logic [1:0]          Lives,
   output logic                q_Idle,
   output logic                q_Launch,
   output logic                q_Air,
   output logic                q_Judge,
   output logic                q_Ack,
   output logic                q_Over
);

   ctrlState_t  state_q, state_d;
   logic [7:0]  peak_q, peak_d;
   logic [15:0] score_q, score_d;
   logic [7:0]  level_q, level_d;
   logic [1:0]  lives_q, lives_d;
   logic        overPend_q, overPend_d;
   logic [7:0]  lfsr_q;

   logic [3:0]  jmpVec;
   logic        jmpI, jmpAir, jmpDone;
   logic        fifoPush, fifoPop, fifoFlush, fifoFull, fifoEmpty;
   logic [7:0]  fifoDout, head, newGap;
   logic        hit;
   logic [16:0] scoreSum;
   logic        wdFire;

`ifdef DOODLE_WATCHDOG_EN
   localparam logic [9:0] WD_LAST = 10'(WD_CYCLES - 1);
   logic [9:0] wdCnt_q, wdCnt_d;
   logic       wdTrip_q, wdTrip_d;
   assign wdFire = ((state_q == ST_LAUNCH) || (state_q == ST_AIR)) && (wdCnt_q == WD_LAST);
`else
   assign wdFire = 1'b0;
`endif

   // Any jumper state that is not exactly one-hot decodes to nothing and holds the controller
   assign jmpVec  = {jmp.q_Done, jmp.q_Down, jmp.q_Up, jmp.q_I};
   assign jmpI    = (jmpVec == JMP_I);
   assign jmpAir  = (jmpVec == JMP_UP) || (jmpVec == JMP_DOWN);
   assign jmpDone = (jmpVec == JMP_DONE);

   assign newGap   = gapFrom(lfsr_q, GAP_MIN);
   assign head     = fifoEmpty ? 8'd0 : fifoDout;
   assign hit      = (peak_q >= head);
   assign scoreSum = {1'b0, score_q} + {9'd0, head};

   doodle_gap_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) uGapFifo (
      .Clk   (Clk),
      .Reset (Reset),
      .push  (fifoPush),
      .pop   (fifoPop),
      .flush (fifoFlush),
      .din   (newGap),
      .dout  (fifoDout),
      .full  (fifoFull),
      .empty (fifoEmpty)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsrNext(lfsr_q);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (BtnStart && fifoFull) state_d = ST_LAUNCH;
         ST_LAUNCH: if (jmpAir) state_d = ST_AIR;
         ST_AIR:    if (jmpDone) state_d = ST_JUDGE;
         ST_JUDGE:  state_d = ST_ACK;
         ST_ACK:    if (jmpI) state_d = overPend_q ? ST_OVER : ST_LAUNCH;
         ST_OVER:   if (BtnAck) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (wdFire) begin
         state_d = ST_JUDGE;
      end
   end

   // Refill runs every cycle; a hit pops and refills together so the queue stays full
   always_comb begin
      peak_d     = peak_q;
      score_d    = score_q;
      level_d    = level_q;
      lives_d    = lives_q;
      overPend_d = overPend_q;
      fifoPop    = 1'b0;
      fifoFlush  = 1'b0;
      case (state_q)
         ST_LAUNCH: peak_d = 8'd0;
         ST_AIR: begin
            if (jmpAir && (jmp.Curr > peak_q)) begin
               peak_d = jmp.Curr;
            end
         end
         ST_JUDGE: begin
            if (hit) begin
               fifoPop = 1'b1;
               score_d = scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
               level_d = (level_q == 8'hFF) ? 8'hFF : level_q + 8'd1;
            end else begin
               lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
               if (lives_q <= 2'd1) begin
                  overPend_d = 1'b1;
               end
            end
         end
         ST_OVER: begin
            if (BtnAck) begin
               fifoFlush  = 1'b1;
               score_d    = 16'd0;
               level_d    = 8'd0;
               lives_d    = LIVES;
               overPend_d = 1'b0;
            end
         end
         default: ;
      endcase
      if (wdFire) begin
         peak_d = 8'd0;
      end
      fifoPush = !fifoFull || fifoPop;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         peak_q     <= 8'd0;
         score_q    <= 16'd0;
         level_q    <= 8'd0;
         lives_q    <= LIVES;
         overPend_q <= 1'b0;
      end else begin
         peak_q     <= peak_d;
         score_q    <= score_d;
         level_q    <= level_d;
         lives_q    <= lives_d;
         overPend_q <= overPend_d;
      end
   end

   always_comb begin
      jmp.Start  = (state_q == ST_LAUNCH);
      jmp.Ack    = (state_q == ST_ACK);
      jmp.Jin    = JUMP;
      q_Idle     = (state_q == ST_IDLE);
      q_Launch   = (state_q == ST_LAUNCH);
      q_Air      = (state_q == ST_AIR);
      q_Judge    = (state_q == ST_JUDGE);
      q_Ack      = (state_q == ST_ACK);
      q_Over     = (state_q == ST_OVER);
      Platform   = head;
      TotalScore = score_q;
      Level      = level_q;
      Lives      = lives_q;
   end

`ifdef DOODLE_WATCHDOG_EN
   // Count time spent waiting on the jumper; restart whenever the state changes
   always_comb begin
      wdCnt_d  = wdCnt_q;
      wdTrip_d = wdTrip_q;
      if (state_d != state_q) begin
         wdCnt_d = 10'd0;
      end else if ((state_q == ST_LAUNCH) || (state_q == ST_AIR)) begin
         wdCnt_d = wdCnt_q + 10'd1;
      end
      if (wdFire) begin
         wdTrip_d = 1'b1;
      end else if ((state_q == ST_OVER) && BtnAck) begin
         wdTrip_d = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wdCnt_q  <= 10'd0;
         wdTrip_q <= 1'b0;
      end else begin
         wdCnt_q  <= wdCnt_d;
         wdTrip_q <= wdTrip_d;
      end
   end

   assign WdTrip = wdTrip_q;
`endif

endmodule

// File: tb/tb_doodle_game_ctrl.sv
// Self-checking bench for doodle_game_ctrl: scripted jumper, randomized jumps, queue-based reference model.
module tb_doodle_game_ctrl;

   localparam logic [3:0] J_I    = 4'b0001;
   localparam logic [3:0] J_UP   = 4'b0010;
   localparam logic [3:0] J_DOWN = 4'b0100;
   localparam logic [3:0] J_DONE = 4'b1000;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        BtnStart, BtnAck;
   logic [7:0]  Platform, Level;
   logic [15:0] TotalScore;
   logic [1:0]  Lives;
   logic        q_Idle, q_Launch, q_Air, q_Judge, q_Ack, q_Over;
`ifdef DOODLE_WATCHDOG_EN
   logic        WdTrip;
`endif

   int checks   = 0;
   int failures = 0;
   int expScore, expLevel, expLives;

   // Reference model: free-running LFSR and a queue of pending gaps
   int         gapQ[$];
   logic [7:0] lfsrM;
   bit         popReq   = 1'b0;
   bit         flushReq = 1'b0;

   doodle_game_ctrl_if bif ();

   doodle_game_ctrl dut (
      .Clk        (Clk),
      .Reset      (Reset),
`ifdef DOODLE_WATCHDOG_EN
      .WdTrip     (WdTrip),
`endif
      .BtnStart   (BtnStart),
      .BtnAck     (BtnAck),
      .jmp        (bif),
      .Platform   (Platform),
      .TotalScore (TotalScore),
      .Level      (Level),
      .Lives      (Lives),
      .q_Idle     (q_Idle),
      .q_Launch   (q_Launch),
      .q_Air      (q_Air),
      .q_Judge    (q_Judge),
      .q_Ack      (q_Ack),
      .q_Over     (q_Over)
   );

   always #5 Clk = ~Clk;

   // Polynomial x^8+x^6+x^5+x^4+1: feedback from the low bit lands on bits 7,5,4,3 after the shift
   function automatic logic [7:0] stepLfsr(input logic [7:0] v);
      logic       fb;
      logic [7:0] s;
      fb = v[0];
      s  = v >> 1;
      if (fb) begin
         s[7] = ~s[7];
         s[5] = ~s[5];
         s[4] = ~s[4];
         s[3] = ~s[3];
      end
      return s;
   endfunction

   function automatic int headM();
      return (gapQ.size() > 0) ? gapQ[0] : 0;
   endfunction

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         lfsrM = 8'hA5;
         gapQ.delete();
      end else begin
         if (flushReq) begin
            gapQ.delete();
         end else begin
            if (popReq && gapQ.size() > 0) void'(gapQ.pop_front());
            if (gapQ.size() < 4) gapQ.push_back(8 + int'(lfsrM % 64));
         end
         lfsrM = stepLfsr(lfsrM);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive jumper state and buttons at the negedge, let one active edge pass, return at the next negedge
   task automatic applyStimulus(input logic [3:0] js, input logic [7:0] curr, input logic bs, input logic ba);
      bif.q_I    = js[0];
      bif.q_Up   = js[1];
      bif.q_Down = js[2];
      bif.q_Done = js[3];
      bif.Curr   = curr;
      BtnStart   = bs;
      BtnAck     = ba;
      @(posedge Clk);
      @(negedge Clk);
      BtnStart = 1'b0;
      BtnAck   = 1'b0;
   endtask

   task automatic startGame();
      applyStimulus(J_I, 8'd0, 1'b1, 1'b0);
      checkOutput("start_1clk_after_btn", {31'd0, bif.Start}, 1);
      checkOutput("launch_state", {31'd0, q_Launch}, 1);
   endtask

   // One jump from LAUNCH through JUDGE and ACK back to LAUNCH or OVER
   task automatic doJump(input int peak, input bit glitchLaunch, input bit glitchAir,
                         input int airLen, input int ackHold);
      int head;
      int peakIdx;
      bit hit;
      head = headM();
      if (glitchLaunch) begin
         applyStimulus(J_DONE, 8'd0, 1'b0, 1'b0);
         checkOutput("launch_ignores_done", {31'd0, q_Launch}, 1);
      end
      applyStimulus(J_UP, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      checkOutput("start_drops_on_qi_low", {31'd0, bif.Start}, 0);
      checkOutput("air_state", {31'd0, q_Air}, 1);
      peakIdx = int'($urandom_range(0, airLen - 1));
      for (int i = 0; i < airLen; i++) begin
         applyStimulus((i < (airLen + 1) / 2) ? J_UP : J_DOWN,
                       (i == peakIdx) ? 8'(peak) : 8'($urandom_range(0, peak)), 1'b0, 1'b0);
         if (glitchAir && i == 0) begin
            applyStimulus(J_UP | J_DONE, 8'hFF, 1'b0, 1'b0);
            checkOutput("air_holds_on_bad_state", {31'd0, q_Air}, 1);
         end
      end
      applyStimulus(J_DONE, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      checkOutput("judge_state", {31'd0, q_Judge}, 1);
      checkOutput("ack_low_in_judge", {31'd0, bif.Ack}, 0);
      hit = (peak >= head);
      if (hit) begin
         popReq   = 1'b1;
         expScore = (expScore + head > 65535) ? 65535 : expScore + head;
         expLevel = (expLevel >= 255) ? 255 : expLevel + 1;
      end else if (expLives > 0) begin
         expLives--;
      end
      applyStimulus(J_DONE, 8'd0, 1'b0, 1'b0);
      popReq = 1'b0;
      checkOutput("ack_2clk_after_done", {31'd0, bif.Ack}, 1);
      checkOutput("score", {16'd0, TotalScore}, expScore);
      checkOutput("level", {24'd0, Level}, expLevel);
      checkOutput("lives", {30'd0, Lives}, expLives);
      checkOutput("platform_head", {24'd0, Platform}, headM());
      for (int i = 0; i < ackHold; i++) begin
         applyStimulus(J_DONE, 8'd0, 1'b0, 1'b0);
         checkOutput("ack_held", {31'd0, bif.Ack}, 1);
      end
      applyStimulus(J_I, 8'd0, 1'b0, 1'b0);
      checkOutput("ack_released", {31'd0, bif.Ack}, 0);
      if (expLives == 0) begin
         checkOutput("over_state", {31'd0, q_Over}, 1);
      end else begin
         checkOutput("relaunch_1clk_after_qi", {31'd0, bif.Start}, 1);
      end
   endtask

   initial begin
      int head;
      Reset    = 1'b1;
      BtnStart = 1'b0;
      BtnAck   = 1'b0;
      bif.q_I = 1'b1; bif.q_Up = 1'b0; bif.q_Down = 1'b0; bif.q_Done = 1'b0; bif.Curr = 8'd0;
      expScore = 0; expLevel = 0; expLives = 3;
      repeat (2) @(negedge Clk);
      checkOutput("rst_idle", {31'd0, q_Idle}, 1);
      checkOutput("rst_start", {31'd0, bif.Start}, 0);
      checkOutput("rst_ack", {31'd0, bif.Ack}, 0);
      checkOutput("rst_platform", {24'd0, Platform}, 0);
      checkOutput("rst_lives", {30'd0, Lives}, 3);
      checkOutput("rst_score", {16'd0, TotalScore}, 0);
      checkOutput("rst_level", {24'd0, Level}, 0);
      checkOutput("jin_const", {24'd0, bif.Jin}, 40);
`ifdef DOODLE_WATCHDOG_EN
      checkOutput("rst_wdtrip", {31'd0, WdTrip}, 0);
`endif
      Reset = 1'b0;

      // Start pressed while the queue is still filling must be dropped
      applyStimulus(J_I, 8'd0, 1'b1, 1'b0);
      checkOutput("start_ignored_not_full", {31'd0, q_Idle}, 1);
      checkOutput("no_start_when_not_full", {31'd0, bif.Start}, 0);
      repeat (3) applyStimulus(J_I, 8'd0, 1'b0, 1'b0);
      checkOutput("platform_first_gap", {24'd0, Platform}, 8 + (8'hA5 & 8'h3F));
      checkOutput("platform_model", {24'd0, Platform}, headM());

      applyStimulus(J_I, 8'd0, 1'b0, 1'b1);
      checkOutput("ack_ignored_in_idle", {31'd0, q_Idle}, 1);
      checkOutput("no_flush_in_idle", {24'd0, Platform}, headM());

      repeat ($urandom_range(0, 5)) applyStimulus(J_I, 8'd0, 1'b0, 1'b0);
      startGame();

      head = headM();
      doJump(head, 1'b1, 1'b0, 1, 0);
      head = headM();
      doJump(head - 1, 1'b0, 1'b1, 3, 0);
      head = headM();
      doJump(head + int'($urandom_range(0, 20)), 1'b0, 1'b0, int'($urandom_range(1, 4)), 2);
      head = headM();
      doJump(int'($urandom_range(0, head - 1)), 1'b0, 1'b0, int'($urandom_range(1, 4)), 1);
      head = headM();
      doJump(head + int'($urandom_range(0, 20)), 1'b0, 1'b0, int'($urandom_range(1, 4)), 0);
      head = headM();
      doJump(int'($urandom_range(0, head - 1)), 1'b0, 1'b0, 2, 0);

      applyStimulus(J_I, 8'd0, 1'b1, 1'b0);
      checkOutput("start_ignored_in_over", {31'd0, q_Over}, 1);
      checkOutput("over_score_frozen", {16'd0, TotalScore}, expScore);
      checkOutput("over_lives_zero", {30'd0, Lives}, 0);

      flushReq = 1'b1;
      applyStimulus(J_I, 8'd0, 1'b0, 1'b1);
      flushReq = 1'b0;
      expScore = 0; expLevel = 0; expLives = 3;
      checkOutput("btnack_to_idle", {31'd0, q_Idle}, 1);
      checkOutput("btnack_score", {16'd0, TotalScore}, 0);
      checkOutput("btnack_level", {24'd0, Level}, 0);
      checkOutput("btnack_lives", {30'd0, Lives}, 3);
      checkOutput("btnack_flushed", {24'd0, Platform}, headM());

      repeat (4 + $urandom_range(0, 3)) applyStimulus(J_I, 8'd0, 1'b0, 1'b0);
      checkOutput("refill_head", {24'd0, Platform}, headM());
      startGame();

      // Hit streak long enough to saturate both level and score
      for (int n = 0; n < 2600 && expScore < 65535; n++) begin
         doJump(headM() + int'($urandom_range(0, 10)), 1'b0, 1'b0, 1, 0);
      end
      repeat (2) doJump(headM() + 1, 1'b0, 1'b0, 1, 0);
      checkOutput("score_saturated", {16'd0, TotalScore}, 32'h0000FFFF);
      checkOutput("level_saturated", {24'd0, Level}, 255);

      applyStimulus(J_UP, 8'd50, 1'b0, 1'b0);
      checkOutput("air_before_reset", {31'd0, q_Air}, 1);
      #3 Reset = 1'b1;
      #1;
      expScore = 0; expLevel = 0; expLives = 3;
      checkOutput("async_rst_idle", {31'd0, q_Idle}, 1);
      checkOutput("async_rst_air", {31'd0, q_Air}, 0);
      checkOutput("async_rst_start", {31'd0, bif.Start}, 0);
      checkOutput("async_rst_ack", {31'd0, bif.Ack}, 0);
      checkOutput("async_rst_score", {16'd0, TotalScore}, 0);
      checkOutput("async_rst_level", {24'd0, Level}, 0);
      checkOutput("async_rst_lives", {30'd0, Lives}, 3);
      checkOutput("async_rst_platform", {24'd0, Platform}, 0);
      @(negedge Clk);
      Reset = 1'b0;
      applyStimulus(J_I, 8'd0, 1'b0, 1'b0);
      checkOutput("post_rst_idle", {31'd0, q_Idle}, 1);
      checkOutput("post_rst_platform", {24'd0, Platform}, headM());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
